// File: rtl/da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic accumulator.
package da_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } da_state_t;

  function automatic int lut_w(input int coef_w, input int k);
    return coef_w + $clog2(k);
  endfunction

  function automatic int acc_w(input int n, input int coef_w, input int k);
    return n + lut_w(coef_w, k);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational DA look-up: sum of the coefficients whose tap bit is set.
module da_lut
  import da_pkg::*;
#(
  parameter int K      = 4,
  parameter int COEF_W = 16,
  parameter int LUT_W  = lut_w(COEF_W, K)
) (
  input  logic        [K*COEF_W-1:0] i_coef,
  input  logic        [K-1:0]        i_x_bits,
  output logic signed [LUT_W-1:0]    o_lut
);

  always_comb begin
    o_lut = '0;
    for (int i = 0; i < K; i++) begin
      if (i_x_bits[i]) begin
        o_lut = o_lut + LUT_W'($signed(i_coef[i*COEF_W +: COEF_W]));
      end
    end
  end

endmodule

// File: rtl/da_accumulator.sv
// Bit-serial distributed-arithmetic FIR accumulator with ready/valid result.
// Define DA_SAT_EN to clamp out-of-range results (sat flag); default wraps.
//
// state | meaning
// IDLE  | waiting for start; coefficient writes accepted
// LOAD  | one-cycle parallel load of the sample shift registers, acc cleared
// ACCUM | N bit-serial cycles, LSB first; last cycle handles the sign bit
// DONE  | result held on y with y_valid until y_ready
module da_accumulator
  import da_pkg::*;
#(
  parameter int K         = 4,
  parameter int N         = 20,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K-1:0]          x_bits,
  output logic                  load,
  output logic                  shift_en,
  input  logic                  coef_we,
  input  logic [K*COEF_W-1:0]   coef,
  output logic                  busy,
  output logic [OUT_W-1:0]      y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  sat
);

  localparam int LUT_W = lut_w(COEF_W, K);
  localparam int ACC_W = acc_w(N, COEF_W, K);
  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] J_LAST = CNT_W'(N - 1);

  da_state_t               r_state;
  da_state_t               w_state_next;
  logic [CNT_W-1:0]        r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic [K*COEF_W-1:0]     r_coef;
  logic [OUT_W-1:0]        r_y;
  logic                    r_sat;

  logic signed [LUT_W-1:0] w_lut;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [OUT_W-1:0]        w_y_red;
  logic                    w_sat_red;
  logic                    w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD:    w_state_next = ACCUM;
      ACCUM:   if (w_last) w_state_next = DONE;
      DONE:    if (y_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    y_valid  = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE:    busy = 1'b0;
      LOAD:    load = 1'b1;
      ACCUM:   shift_en = 1'b1;
      DONE:    y_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  da_lut #(
    .K      (K),
    .COEF_W (COEF_W),
    .LUT_W  (LUT_W)
  ) u_lut (
    .i_coef   (r_coef),
    .i_x_bits (x_bits),
    .o_lut    (w_lut)
  );

  // The MSB of a two's-complement sample carries negative weight.
  assign w_last     = (r_j == J_LAST);
  assign w_term     = ACC_W'(w_lut) << r_j;
  assign w_acc_next = w_last ? (r_acc - w_term) : (r_acc + w_term);

`ifdef DA_SAT_EN
  logic signed [ACC_W-1:0] w_shifted;
  logic [ACC_W-OUT_W:0]    w_upper;

  assign w_shifted = w_acc_next >>> OUT_SHIFT;
  assign w_upper   = w_shifted[ACC_W-1:OUT_W-1];

  // In range only when every bit above the output sign matches it.
  always_comb begin
    w_y_red   = w_shifted[OUT_W-1:0];
    w_sat_red = 1'b0;
    if (!((&w_upper) || !(|w_upper))) begin
      w_sat_red = 1'b1;
      w_y_red   = w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign w_y_red   = OUT_W'(w_acc_next >>> OUT_SHIFT);
  assign w_sat_red = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j    <= '0;
      r_acc  <= '0;
      r_coef <= '0;
      r_y    <= '0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (coef_we) r_coef <= coef;
        end
        LOAD: begin
          r_acc <= '0;
          r_j   <= '0;
        end
        ACCUM: begin
          r_acc <= w_acc_next;
          r_j   <= r_j + CNT_W'(1);
          if (w_last) begin
            r_y   <= w_y_red;
            r_sat <= w_sat_red;
          end
        end
        default: ;
      endcase
    end
  end

  assign y   = r_y;
  assign sat = r_sat;

endmodule

// File: tb/tb_da_accumulator.sv
// Self-checking bench for da_accumulator (K=4, N=8, COEF_W=8, OUT_W=16).
module tb_da_accumulator;

  localparam int K  = 4;
  localparam int N  = 8;
  localparam int CW = 8;
  localparam int OW = 16;

  typedef logic [CW-1:0] coefs_t [K];
  typedef logic [N-1:0]  samps_t [K];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic coef_we = 1'b0;
  logic y_ready = 1'b0;
  logic [K*CW-1:0] coef = '0;
  logic [K-1:0] x_bits;
  logic load, shift_en, busy, y_valid, sat;
  logic [OW-1:0] y;

  samps_t samp = '{default: '0};
  samps_t sr   = '{default: '0};

  int n_pass = 0;
  int n_checks = 0;
  int n_loads = 0;
  int n_results = 0;
  logic [OW-1:0] exp_y = '0;
  logic exp_sat = 1'b0;
  logic exp_armed = 1'b0;
  logic y_valid_d = 1'b0;

  always #5 clk = ~clk;

  da_accumulator #(
    .K(K), .N(N), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_bits(x_bits),
    .load(load), .shift_en(shift_en), .coef_we(coef_we), .coef(coef),
    .busy(busy), .y(y), .y_valid(y_valid), .y_ready(y_ready), .sat(sat)
  );

  // Sample shift registers driven by the DUT's load / shift strobes.
  always @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (load) sr[i] <= samp[i];
      else if (shift_en) sr[i] <= sr[i] >> 1;
    end
  end

  always_comb begin
    x_bits = '0;
    for (int i = 0; i < K; i++) x_bits[i] = sr[i][0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: signed dot product of coefficients and N-bit two's-complement samples.
  function automatic void model(input coefs_t c, input samps_t s,
                                output logic [OW-1:0] ry, output logic rsat);
    longint acc = 0;
    longint mx = (longint'(1) << (OW - 1)) - 1;
    longint mn = -mx - 1;
    for (int i = 0; i < K; i++)
      acc += longint'($signed(c[i])) * longint'($signed(s[i]));
    ry = acc[OW-1:0];
    rsat = 1'b0;
`ifdef DA_SAT_EN
    if (acc > mx) begin ry = mx[OW-1:0]; rsat = 1'b1; end
    else if (acc < mn) begin ry = mn[OW-1:0]; rsat = 1'b1; end
`else
    if (mx == mn) rsat = 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("load_shift_excl", 64'(load & shift_en), 64'(0));
      if (y_valid) begin
        chk("y_valid_expected", 64'(exp_armed), 64'(1));
        chk("y_model", 64'(y), 64'(exp_y));
        chk("sat_model", 64'(sat), 64'(exp_sat));
      end
      if (load) n_loads++;
      if (y_valid && !y_valid_d) n_results++;
    end
    y_valid_d = y_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coefs(input coefs_t c);
    for (int i = 0; i < K; i++) coef[i*CW +: CW] = c[i];
    coef_we = 1'b1;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic begin_run(input coefs_t c_model, input samps_t s, output int lat);
    samp = s;
    model(c_model, s, exp_y, exp_sat);
    exp_armed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_valid(inout int lat);
    while (!y_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(N + 2));
  endtask

  task automatic launch(input coefs_t c_model, input samps_t s);
    int lat;
    begin_run(c_model, s, lat);
    wait_valid(lat);
  endtask

  task automatic accept(input int hold, input logic start_too);
    y_ready = 1'b0;
    repeat (hold) tick();
    y_ready = 1'b1;
    start = start_too;
    tick();
    y_ready = 1'b0;
    start = 1'b0;
    exp_armed = 1'b0;
    chk("idle_after_accept", 64'(busy), 64'(0));
  endtask

  coefs_t ca, cb;
  samps_t sa;
  logic [OW-1:0] y_hold;
  int loads_snap, results_snap, lat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", 64'(load), 64'(0));
    chk("rst_shift_en", 64'(shift_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_y_valid", 64'(y_valid), 64'(0));
    chk("rst_sat", 64'(sat), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    rst_n = 1'b1;
    tick();

    ca = '{8'd1, 8'd2, 8'd3, 8'd4};
    sa = '{8'd1, 8'd1, 8'd1, 8'd1};
    write_coefs(ca);
    launch(ca, sa);
    chk("t1_y", 64'(y), 64'(16'd10));
    chk("t1_sat", 64'(sat), 64'(0));
    accept(0, 1'b0);

    ca = '{8'd1, 8'd0, 8'd0, 8'd0};
    sa = '{8'hFF, 8'h00, 8'h00, 8'h00};
    write_coefs(ca);
    launch(ca, sa);
    chk("t2_y", 64'(y), 64'(16'hFFFF));
    accept(1, 1'b0);

    ca = '{8'd127, 8'd127, 8'd127, 8'd127};
    sa = '{8'h80, 8'h80, 8'h80, 8'h80};
    write_coefs(ca);
    launch(ca, sa);
`ifdef DA_SAT_EN
    chk("t3_y", 64'(y), 64'(16'h8000));
    chk("t3_sat", 64'(sat), 64'(1));
`else
    chk("t3_y", 64'(y), 64'(16'd512));
    chk("t3_sat", 64'(sat), 64'(0));
`endif
    accept(0, 1'b0);

    // Back-pressure: y held, start ignored while DONE and at the handshake.
    ca = '{8'd3, 8'hFE, 8'd5, 8'd7};
    sa = '{8'h11, 8'h22, 8'h05, 8'h40};
    write_coefs(ca);
    results_snap = n_results;
    launch(ca, sa);
    chk("t4_y", 64'(y), 64'(16'd456));
    loads_snap = n_loads;
    y_hold = y;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("t4_hold_y", 64'(y), 64'(y_hold));
      chk("t4_hold_valid", 64'(y_valid), 64'(1));
    end
    start = 1'b0;
    accept(0, 1'b1);
    repeat (3) tick();
    chk("t4_no_new_load", 64'(n_loads), 64'(loads_snap));
    chk("t4_one_result", 64'(n_results), 64'(results_snap + 1));
    chk("t4_idle", 64'(busy), 64'(0));

    // Reset during ACCUM at j=3.
    ca = '{8'd9, 8'd8, 8'd7, 8'd6};
    sa = '{8'h12, 8'h34, 8'h56, 8'h78};
    write_coefs(ca);
    samp = sa;
    exp_armed = 1'b0;
    results_snap = n_results;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t5_in_accum", 64'(shift_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_load", 64'(load), 64'(0));
    chk("t5_rst_shift_en", 64'(shift_en), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_y_valid", 64'(y_valid), 64'(0));
    chk("t5_rst_sat", 64'(sat), 64'(0));
    chk("t5_rst_y", 64'(y), 64'(0));
    tick();
    rst_n = 1'b1;
    repeat (N + 4) tick();
    chk("t5_no_result", 64'(n_results), 64'(results_snap));
    cb = '{8'd0, 8'd0, 8'd0, 8'd0};
    launch(cb, sa);
    chk("t5_cleared_coefs_y", 64'(y), 64'(0));
    accept(0, 1'b0);
    write_coefs(ca);
    launch(ca, sa);
    accept(2, 1'b0);

    // coef_we during ACCUM must not change the coefficients in use.
    ca = '{8'd5, 8'hF6, 8'd20, 8'd1};
    cb = '{8'd100, 8'd100, 8'd100, 8'd100};
    sa = '{8'h0F, 8'hA5, 8'h3C, 8'h81};
    write_coefs(ca);
    begin_run(ca, sa, lat);
    tick(); lat++;
    tick(); lat++;
    for (int i = 0; i < K; i++) coef[i*CW +: CW] = cb[i];
    coef_we = 1'b1;
    tick(); lat++;
    coef_we = 1'b0;
    wait_valid(lat);
    accept(0, 1'b0);
    launch(ca, sa);
    accept(0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < K; i++) begin
        ca[i] = 8'($urandom_range(0, 255));
        sa[i] = 8'($urandom_range(0, 255));
      end
      write_coefs(ca);
      launch(ca, sa);
      accept($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1);
  end

endmodule
